// File: rtl/segre_pkg.sv
// Shared writeback-stage types: source tags, buffered entry layout and default sizing.
// Entry field widths here fix the data/address widths of segre_wb_stage.
package segre_pkg;

  localparam int WB_WORD_SIZE    = 32;
  localparam int WB_REG_ADDR_W   = 5;
  localparam int WB_DEPTH        = 8;
  localparam int WB_STALL_THRESH = 5;

  typedef enum logic [1:0] {
    WB_EX,
    WB_MEM,
    WB_RVM
  } wb_src_e;

  // src only tags where a write came from; no datapath decision depends on it
  typedef struct packed {
    logic [WB_REG_ADDR_W-1:0] waddr;
    logic [WB_WORD_SIZE-1:0]  data;
    wb_src_e                  src;
  } wb_entry_t;

endpackage

// File: rtl/segre_wb_lookup.sv
// Youngest-match search over the live window [head, head+count) of the writeback buffer.
// Purely combinational; x0 never hits, data is zero on a miss.
module segre_wb_lookup
  import segre_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int ADDR_W = WB_REG_ADDR_W,
  parameter int DATA_W = WB_WORD_SIZE,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0] ent_waddr [DEPTH],
  input  logic [DATA_W-1:0] ent_data  [DEPTH],
  input  logic [PTR_W-1:0]  head,
  input  logic [PTR_W:0]    count,
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  logic [PTR_W-1:0] slot;

  // Walk oldest to youngest so the last match seen is the youngest one
  always_comb begin
    hit  = 1'b0;
    data = '0;
    slot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head + PTR_W'(i);
      if (((PTR_W+1)'(i) < count) && (ent_waddr[slot] == addr) && (addr != '0)) begin
        hit  = 1'b1;
        data = ent_data[slot];
      end
    end
  end

endmodule

// File: rtl/segre_wb_stage.sv
// Funnels up to three EX/MEM/RVM writes per cycle in order into one RF write port; one-cycle
// minimum latency, stall_o raised near capacity, excess writes dropped with a sticky overflow flag.
module segre_wb_stage
  import segre_pkg::*;
#(
  parameter int WORD_SIZE    = WB_WORD_SIZE,
  parameter int REG_ADDR_W   = WB_REG_ADDR_W,
  parameter int DEPTH        = WB_DEPTH,
  parameter int STALL_THRESH = WB_STALL_THRESH
) (
  input  logic                  clk_i,
  input  logic                  rsn_i,
  input  logic                  ex_we_i,
  input  logic [REG_ADDR_W-1:0] ex_waddr_i,
  input  logic [WORD_SIZE-1:0]  ex_data_i,
  input  logic                  mem_we_i,
  input  logic [REG_ADDR_W-1:0] mem_waddr_i,
  input  logic [WORD_SIZE-1:0]  mem_data_i,
  input  logic                  rvm_we_i,
  input  logic [REG_ADDR_W-1:0] rvm_waddr_i,
  input  logic [WORD_SIZE-1:0]  rvm_data_i,
  output logic                  rf_we_o,
  output logic [REG_ADDR_W-1:0] rf_waddr_o,
  output logic [WORD_SIZE-1:0]  rf_wdata_o,
  input  logic [REG_ADDR_W-1:0] rd_addr_a_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_b_i,
  output logic                  byp_hit_a_o,
  output logic [WORD_SIZE-1:0]  byp_data_a_o,
  output logic                  byp_hit_b_o,
  output logic [WORD_SIZE-1:0]  byp_data_b_o,
  output logic                  stall_o,
  output logic                  overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             overflow_q;

  wb_entry_t        req     [3];
  logic [2:0]       req_vld;
  logic [2:0]       wr_en;
  logic [PTR_W-1:0] wr_slot [3];
  logic [1:0]       n_enq;
  logic [CNT_W-1:0] space;
  logic             deq;
  logic             drop;

  assign deq   = (count != '0);
  assign space = CNT_W'(DEPTH) - count + CNT_W'(deq);

  always_comb begin
    req[0]     = '{waddr: ex_waddr_i,  data: ex_data_i,  src: WB_EX};
    req[1]     = '{waddr: mem_waddr_i, data: mem_data_i, src: WB_MEM};
    req[2]     = '{waddr: rvm_waddr_i, data: rvm_data_i, src: WB_RVM};
    req_vld[0] = ex_we_i  && (ex_waddr_i  != '0);
    req_vld[1] = mem_we_i && (mem_waddr_i != '0);
    req_vld[2] = rvm_we_i && (rvm_waddr_i != '0);
  end

  // Compact surviving requests onto consecutive slots; once space runs out the rest drop
  always_comb begin
    n_enq = '0;
    drop  = 1'b0;
    wr_en = '0;
    for (int s = 0; s < 3; s++) begin
      wr_slot[s] = tail + PTR_W'(n_enq);
      if (req_vld[s]) begin
        if (CNT_W'(n_enq) < space) begin
          wr_en[s] = 1'b1;
          n_enq    = n_enq + 2'd1;
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      head       <= head + PTR_W'(deq);
      tail       <= tail + PTR_W'(n_enq);
      count      <= count + CNT_W'(n_enq) - CNT_W'(deq);
      overflow_q <= overflow_q | drop;
    end
  end

  // Storage needs no reset: count gates every read of it
  always_ff @(posedge clk_i) begin
    for (int s = 0; s < 3; s++) begin
      if (wr_en[s]) mem[wr_slot[s]] <= req[s];
    end
  end

  assign rf_we_o    = deq;
  assign rf_waddr_o = deq ? mem[head].waddr : '0;
  assign rf_wdata_o = deq ? mem[head].data  : '0;
  assign stall_o    = (count >= CNT_W'(STALL_THRESH));
  assign overflow_o = overflow_q;

  logic [REG_ADDR_W-1:0] ent_waddr [DEPTH];
  logic [WORD_SIZE-1:0]  ent_data  [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    assign ent_waddr[g] = mem[g].waddr;
    assign ent_data[g]  = mem[g].data;
  end

  segre_wb_lookup #(
    .DEPTH (DEPTH),
    .ADDR_W(REG_ADDR_W),
    .DATA_W(WORD_SIZE)
  ) u_lookup_a (
    .ent_waddr(ent_waddr),
    .ent_data (ent_data),
    .head     (head),
    .count    (count),
    .addr     (rd_addr_a_i),
    .hit      (byp_hit_a_o),
    .data     (byp_data_a_o)
  );

  segre_wb_lookup #(
    .DEPTH (DEPTH),
    .ADDR_W(REG_ADDR_W),
    .DATA_W(WORD_SIZE)
  ) u_lookup_b (
    .ent_waddr(ent_waddr),
    .ent_data (ent_data),
    .head     (head),
    .count    (count),
    .addr     (rd_addr_b_i),
    .hit      (byp_hit_b_o),
    .data     (byp_data_b_o)
  );

  always @(posedge clk_i) begin
    if (rsn_i) begin
      assert (!drop)
        else $warning("segre_wb_stage: register write dropped, buffer full");
      assert (!deq || (mem[head].src inside {WB_EX, WB_MEM, WB_RVM}))
        else $error("segre_wb_stage: head entry has illegal source tag");
    end
  end

endmodule

// File: tb/tb_segre_wb_stage.sv
// Bench for segre_wb_stage: directed vector table, overflow and reset sequences, random traffic
// checked against a queue-based model of the in-order writeback buffer.
module tb_segre_wb_stage;

  localparam int DEPTH = 8;
  localparam int THRESH = 5;

  logic        clk_i = 1'b0;
  logic        rsn_i;
  logic        ex_we_i, mem_we_i, rvm_we_i;
  logic [4:0]  ex_waddr_i, mem_waddr_i, rvm_waddr_i;
  logic [31:0] ex_data_i, mem_data_i, rvm_data_i;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic [4:0]  rd_addr_a_i, rd_addr_b_i;
  logic        byp_hit_a_o, byp_hit_b_o;
  logic [31:0] byp_data_a_o, byp_data_b_o;
  logic        stall_o, overflow_o;

  always #5 clk_i = ~clk_i;

  segre_wb_stage dut (
    .clk_i       (clk_i),
    .rsn_i       (rsn_i),
    .ex_we_i     (ex_we_i),
    .ex_waddr_i  (ex_waddr_i),
    .ex_data_i   (ex_data_i),
    .mem_we_i    (mem_we_i),
    .mem_waddr_i (mem_waddr_i),
    .mem_data_i  (mem_data_i),
    .rvm_we_i    (rvm_we_i),
    .rvm_waddr_i (rvm_waddr_i),
    .rvm_data_i  (rvm_data_i),
    .rf_we_o     (rf_we_o),
    .rf_waddr_o  (rf_waddr_o),
    .rf_wdata_o  (rf_wdata_o),
    .rd_addr_a_i (rd_addr_a_i),
    .rd_addr_b_i (rd_addr_b_i),
    .byp_hit_a_o (byp_hit_a_o),
    .byp_data_a_o(byp_data_a_o),
    .byp_hit_b_o (byp_hit_b_o),
    .byp_data_b_o(byp_data_b_o),
    .stall_o     (stall_o),
    .overflow_o  (overflow_o)
  );

  typedef struct {
    logic ew; logic [4:0] ea; logic [31:0] ed;
    logic mw; logic [4:0] ma; logic [31:0] md;
    logic rw; logic [4:0] ra; logic [31:0] rd;
    logic [4:0] qa; logic [4:0] qb;
    logic x_we; logic [4:0] x_wa; logic [31:0] x_wd;
    logic x_ha; logic [31:0] x_da;
    logic x_hb; logic [31:0] x_db;
    logic x_st; logic x_ov;
  } vec_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ment_t;

  ment_t q[$];
  bit    m_ovf;
  int    total = 0;
  int    bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(
      input logic ew, input logic [4:0] ea, input logic [31:0] ed,
      input logic mw, input logic [4:0] ma, input logic [31:0] md,
      input logic rw, input logic [4:0] ra, input logic [31:0] rd,
      input logic [4:0] qa, input logic [4:0] qb,
      input logic xwe, input logic [4:0] xwa, input logic [31:0] xwd,
      input logic xha, input logic [31:0] xda,
      input logic xhb, input logic [31:0] xdb,
      input logic xst, input logic xov);
    vec_t v;
    v.ew = ew; v.ea = ea; v.ed = ed;
    v.mw = mw; v.ma = ma; v.md = md;
    v.rw = rw; v.ra = ra; v.rd = rd;
    v.qa = qa; v.qb = qb;
    v.x_we = xwe; v.x_wa = xwa; v.x_wd = xwd;
    v.x_ha = xha; v.x_da = xda; v.x_hb = xhb; v.x_db = xdb;
    v.x_st = xst; v.x_ov = xov;
    return v;
  endfunction

  function automatic vec_t idle(input logic [4:0] qa, input logic [4:0] qb);
    return mk(0,0,0, 0,0,0, 0,0,0, qa,qb, 0,0,0, 0,0, 0,0, 0,0);
  endfunction

  function automatic void model_byp(input logic [4:0] a, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = '0;
    if (a != 0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].a == a) begin
          h = 1'b1;
          d = q[i].d;
          break;
        end
      end
    end
  endfunction

  // One clock edge of the buffer: the oldest write retires, then new writes join in source order
  function automatic void model_step(input vec_t v);
    ment_t e;
    if (q.size() > 0) void'(q.pop_front());
    if (v.ew && v.ea != 0) begin
      e.a = v.ea; e.d = v.ed;
      if (q.size() < DEPTH) q.push_back(e); else m_ovf = 1'b1;
    end
    if (v.mw && v.ma != 0) begin
      e.a = v.ma; e.d = v.md;
      if (q.size() < DEPTH) q.push_back(e); else m_ovf = 1'b1;
    end
    if (v.rw && v.ra != 0) begin
      e.a = v.ra; e.d = v.rd;
      if (q.size() < DEPTH) q.push_back(e); else m_ovf = 1'b1;
    end
  endfunction

  task automatic check_model();
    logic h; logic [31:0] d;
    chk("rf_we", rf_we_o, q.size() != 0);
    chk("rf_waddr", rf_waddr_o, q.size() != 0 ? q[0].a : 5'd0);
    chk("rf_wdata", rf_wdata_o, q.size() != 0 ? q[0].d : 32'd0);
    model_byp(rd_addr_a_i, h, d);
    chk("byp_hit_a", byp_hit_a_o, h);
    chk("byp_data_a", byp_data_a_o, d);
    model_byp(rd_addr_b_i, h, d);
    chk("byp_hit_b", byp_hit_b_o, h);
    chk("byp_data_b", byp_data_b_o, d);
    chk("stall", stall_o, q.size() >= THRESH);
    chk("overflow", overflow_o, m_ovf);
  endtask

  // Entered just after a rising edge; leaves just after the next one
  task automatic run_cycle(input vec_t v, input bit use_tbl);
    ex_we_i = v.ew;  ex_waddr_i = v.ea;  ex_data_i = v.ed;
    mem_we_i = v.mw; mem_waddr_i = v.ma; mem_data_i = v.md;
    rvm_we_i = v.rw; rvm_waddr_i = v.ra; rvm_data_i = v.rd;
    rd_addr_a_i = v.qa; rd_addr_b_i = v.qb;
    @(negedge clk_i);
    if (use_tbl) begin
      chk("tbl rf_we", rf_we_o, v.x_we);
      chk("tbl rf_waddr", rf_waddr_o, v.x_wa);
      chk("tbl rf_wdata", rf_wdata_o, v.x_wd);
      chk("tbl byp_hit_a", byp_hit_a_o, v.x_ha);
      chk("tbl byp_data_a", byp_data_a_o, v.x_da);
      chk("tbl byp_hit_b", byp_hit_b_o, v.x_hb);
      chk("tbl byp_data_b", byp_data_b_o, v.x_db);
      chk("tbl stall", stall_o, v.x_st);
      chk("tbl overflow", overflow_o, v.x_ov);
    end else begin
      check_model();
    end
    @(posedge clk_i);
    model_step(v);
    #1;
  endtask

  task automatic apply_reset();
    rsn_i = 1'b0;
    #1;
    q.delete();
    m_ovf = 1'b0;
    @(posedge clk_i);
    #1;
    rsn_i = 1'b1;
  endtask

  vec_t tbl [15];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [4:0] a0, a1, a2;
    int k;

    rsn_i = 1'b0;
    ex_we_i = 0; ex_waddr_i = 0; ex_data_i = 0;
    mem_we_i = 0; mem_waddr_i = 0; mem_data_i = 0;
    rvm_we_i = 0; rvm_waddr_i = 0; rvm_data_i = 0;
    rd_addr_a_i = 5'd3; rd_addr_b_i = 5'd4;
    m_ovf = 1'b0;
    #2;
    chk("reset rf_we", rf_we_o, 0);
    chk("reset rf_waddr", rf_waddr_o, 0);
    chk("reset rf_wdata", rf_wdata_o, 0);
    chk("reset byp_hit_a", byp_hit_a_o, 0);
    chk("reset byp_data_b", byp_data_b_o, 0);
    chk("reset stall", stall_o, 0);
    chk("reset overflow", overflow_o, 0);
    @(posedge clk_i);
    #1;
    rsn_i = 1'b1;

    // Each row: inputs held for one cycle, outputs expected in that same cycle
    tbl[0]  = mk(1,5,32'hDEADBEEF, 0,0,0, 0,0,0, 5,0, 0,0,0, 0,0, 0,0, 0,0);
    tbl[1]  = mk(0,0,0, 0,0,0, 0,0,0, 5,0, 1,5,32'hDEADBEEF, 1,32'hDEADBEEF, 0,0, 0,0);
    tbl[2]  = idle(5, 0);
    tbl[3]  = mk(1,1,1, 1,2,2, 1,3,3, 2,3, 0,0,0, 0,0, 0,0, 0,0);
    tbl[4]  = mk(0,0,0, 0,0,0, 0,0,0, 2,3, 1,1,1, 1,2, 1,3, 0,0);
    tbl[5]  = mk(0,0,0, 0,0,0, 0,0,0, 2,3, 1,2,2, 1,2, 1,3, 0,0);
    tbl[6]  = mk(0,0,0, 0,0,0, 0,0,0, 2,3, 1,3,3, 0,0, 1,3, 0,0);
    tbl[7]  = mk(1,0,32'hAA, 1,0,32'hBB, 1,0,32'hCC, 0,0, 0,0,0, 0,0, 0,0, 0,0);
    tbl[8]  = idle(0, 0);
    tbl[9]  = mk(1,9,32'h99, 1,8,32'h88, 0,0,0, 7,8, 0,0,0, 0,0, 0,0, 0,0);
    tbl[10] = mk(1,7,32'h10, 0,0,0, 0,0,0, 7,8, 1,9,32'h99, 0,0, 1,32'h88, 0,0);
    tbl[11] = mk(0,0,0, 1,7,32'h20, 0,0,0, 7,8, 1,8,32'h88, 1,32'h10, 1,32'h88, 0,0);
    tbl[12] = mk(0,0,0, 0,0,0, 0,0,0, 7,8, 1,7,32'h10, 1,32'h20, 0,0, 0,0);
    tbl[13] = mk(0,0,0, 0,0,0, 0,0,0, 7,0, 1,7,32'h20, 1,32'h20, 0,0, 0,0);
    tbl[14] = idle(7, 0);
    for (int i = 0; i < 15; i++) run_cycle(tbl[i], 1'b1);

    // Four cycles of triple writes: stall at occupancy 5, RVM write of the fourth cycle dropped
    for (int c = 0; c < 4; c++) begin
      k = 10 + 3 * c;
      v = mk(1,5'(k),32'(k*256), 1,5'(k+1),32'(k*256+256), 1,5'(k+2),32'(k*256+512),
             21,19, 0,0,0, 0,0, 0,0, 0,0);
      run_cycle(v, 1'b0);
      chk("fill stall", stall_o, c >= 1);
      chk("fill overflow", overflow_o, c == 3);
    end
    chk("fill head waddr", rf_waddr_o, 13);
    chk("dropped write not bypassed", byp_hit_a_o, 0);
    for (int c = 0; c < 10; c++) run_cycle(idle(19, 21), 1'b0);
    chk("overflow sticky", overflow_o, 1);
    chk("drained rf_we", rf_we_o, 0);

    // Reset with six pending writes
    apply_reset();
    chk("overflow cleared", overflow_o, 0);
    run_cycle(mk(1,1,32'h11, 1,2,32'h22, 1,3,32'h33, 0,0, 0,0,0, 0,0, 0,0, 0,0), 1'b0);
    run_cycle(mk(1,4,32'h44, 1,5,32'h55, 1,6,32'h66, 0,0, 0,0,0, 0,0, 0,0, 0,0), 1'b0);
    run_cycle(mk(1,7,32'h77, 1,8,32'h88, 0,0,0, 8,6, 0,0,0, 0,0, 0,0, 0,0), 1'b0);
    ex_we_i = 0; mem_we_i = 0; rvm_we_i = 0;
    chk("pre-reset stall", stall_o, 1);
    chk("pre-reset byp_hit_a", byp_hit_a_o, 1);
    rsn_i = 1'b0;
    #1;
    chk("mid reset rf_we", rf_we_o, 0);
    chk("mid reset rf_waddr", rf_waddr_o, 0);
    chk("mid reset rf_wdata", rf_wdata_o, 0);
    chk("mid reset byp_hit_a", byp_hit_a_o, 0);
    chk("mid reset byp_data_a", byp_data_a_o, 0);
    chk("mid reset byp_hit_b", byp_hit_b_o, 0);
    chk("mid reset stall", stall_o, 0);
    q.delete();
    m_ovf = 1'b0;
    @(posedge clk_i);
    #1;
    rsn_i = 1'b1;
    for (int c = 0; c < 5; c++) run_cycle(idle(8, 6), 1'b0);

    // Random traffic, distinct destinations per cycle as the pipelines guarantee
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      a0 = 5'($urandom_range(0, 31));
      do a1 = 5'($urandom_range(0, 31)); while (a1 == a0);
      do a2 = 5'($urandom_range(0, 31)); while (a2 == a0 || a2 == a1);
      v = idle(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if (q.size() != 0 && $urandom_range(0, 1) == 1)
        v.qa = q[$urandom_range(0, q.size() - 1)].a;
      v.ew = ($urandom_range(0, 99) < 45); v.ea = a0; v.ed = $urandom;
      v.mw = ($urandom_range(0, 99) < 45); v.ma = a1; v.md = $urandom;
      v.rw = ($urandom_range(0, 99) < 45); v.ra = a2; v.rd = $urandom;
      run_cycle(v, 1'b0);
      if (c == 200) apply_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
